// File: rtl/acc_wb_buffer_if.sv
// Handshake bundle between the adapter core-side logic and the writeback buffer:
// issue tracking, C-bus responses in, X-response writeback beats out.
interface acc_wb_buffer_if #(
    parameter int DataWidth    = 32,
    parameter int RegAddrWidth = 5,
    parameter int Depth        = 4
);
    localparam int CntWidth = $clog2(Depth + 1);

    logic                    issue_valid_i;
    logic                    issue_ready_o;
    logic [RegAddrWidth-1:0] issue_rd_i;
    logic                    issue_dualwb_i;
    logic                    c_rsp_valid_i;
    logic                    c_rsp_ready_o;
    logic [DataWidth-1:0]    c_rsp_data0_i;
    logic [DataWidth-1:0]    c_rsp_data1_i;
    logic                    c_rsp_error_i;
    logic                    x_rsp_valid_o;
    logic                    x_rsp_ready_i;
    logic [RegAddrWidth-1:0] x_rsp_rd_o;
    logic [DataWidth-1:0]    x_rsp_data_o;
    logic                    x_rsp_error_o;
    logic [CntWidth-1:0]     outstanding_o;

    modport slave (
        input  issue_valid_i, issue_rd_i, issue_dualwb_i,
        input  c_rsp_valid_i, c_rsp_data0_i, c_rsp_data1_i, c_rsp_error_i,
        input  x_rsp_ready_i,
        output issue_ready_o, c_rsp_ready_o,
        output x_rsp_valid_o, x_rsp_rd_o, x_rsp_data_o, x_rsp_error_o,
        output outstanding_o
    );

    modport master (
        output issue_valid_i, issue_rd_i, issue_dualwb_i,
        output c_rsp_valid_i, c_rsp_data0_i, c_rsp_data1_i, c_rsp_error_i,
        output x_rsp_ready_i,
        input  issue_ready_o, c_rsp_ready_o,
        input  x_rsp_valid_o, x_rsp_rd_o, x_rsp_data_o, x_rsp_error_o,
        input  outstanding_o
    );
endinterface

// File: rtl/acc_wb_buffer.sv
// Writeback buffer: pairs in-order C-bus responses with tracked issues and
// emits one register-write beat per cycle, splitting dual writebacks in two.
module acc_wb_buffer #(
    parameter int DataWidth    = 32,
    parameter int Depth        = 4,
    parameter int RegAddrWidth = 5
) (
    input  logic           clk_i,
    input  logic           rst_i,
    acc_wb_buffer_if.slave bus
);
    localparam int CntWidth = $clog2(Depth + 1);
    localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [CntWidth-1:0] DEPTH_C  = CntWidth'(Depth);
    localparam logic [PtrWidth-1:0] PTR_LAST = PtrWidth'(Depth - 1);
    localparam logic [0:0] BEAT0 = 1'b0;
    localparam logic [0:0] BEAT1 = 1'b1;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        if (p == PTR_LAST) begin
            ptr_inc = {PtrWidth{1'b0}};
        end else begin
            ptr_inc = p + PtrWidth'(1);
        end
    endfunction

    logic [RegAddrWidth-1:0] trk_rd_q   [Depth];
    logic [RegAddrWidth-1:0] trk_rd_d   [Depth];
    logic                    trk_dual_q [Depth];
    logic                    trk_dual_d [Depth];
    logic [DataWidth-1:0]    dat0_q     [Depth];
    logic [DataWidth-1:0]    dat0_d     [Depth];
    logic [DataWidth-1:0]    dat1_q     [Depth];
    logic [DataWidth-1:0]    dat1_d     [Depth];
    logic                    dat_err_q  [Depth];
    logic                    dat_err_d  [Depth];

    logic [PtrWidth-1:0]     trk_wptr_q, trk_wptr_d;
    logic [PtrWidth-1:0]     dat_wptr_q, dat_wptr_d;
    logic [PtrWidth-1:0]     rptr_q, rptr_d;
    logic [CntWidth-1:0]     trk_cnt_q, trk_cnt_d;
    logic [CntWidth-1:0]     dat_cnt_q, dat_cnt_d;
    logic [0:0]              beat_q, beat_d;
    logic                    issue_ready_q, issue_ready_d;
    logic                    c_ready_q, c_ready_d;
    logic                    x_valid_q, x_valid_d;
    logic [RegAddrWidth-1:0] x_rd_q, x_rd_d;
    logic [DataWidth-1:0]    x_data_q, x_data_d;
    logic                    x_err_q, x_err_d;

    logic issue_hs_s, rsp_hs_s, x_hs_s, pop_s;

    // Handshakes, FIFO updates, beat sequencing and next-state output values.
    // Outputs are registered from next state so they equal the post-edge FIFO view.
    always_comb begin
        issue_hs_s = bus.issue_valid_i & issue_ready_q;
        rsp_hs_s   = bus.c_rsp_valid_i & c_ready_q;
        x_hs_s     = x_valid_q & bus.x_rsp_ready_i;
        pop_s      = x_hs_s & ((beat_q == BEAT1) | ~trk_dual_q[rptr_q]);

        trk_rd_d   = trk_rd_q;
        trk_dual_d = trk_dual_q;
        dat0_d     = dat0_q;
        dat1_d     = dat1_q;
        dat_err_d  = dat_err_q;

        if (issue_hs_s) begin
            trk_rd_d[trk_wptr_q]   = bus.issue_rd_i;
            trk_dual_d[trk_wptr_q] = bus.issue_dualwb_i;
            trk_wptr_d             = ptr_inc(trk_wptr_q);
        end else begin
            trk_wptr_d = trk_wptr_q;
        end

        if (rsp_hs_s) begin
            dat0_d[dat_wptr_q]    = bus.c_rsp_data0_i;
            dat1_d[dat_wptr_q]    = bus.c_rsp_data1_i;
            dat_err_d[dat_wptr_q] = bus.c_rsp_error_i;
            dat_wptr_d            = ptr_inc(dat_wptr_q);
        end else begin
            dat_wptr_d = dat_wptr_q;
        end

        if (pop_s) begin
            rptr_d = ptr_inc(rptr_q);
        end else begin
            rptr_d = rptr_q;
        end

        case (beat_q)
            BEAT0: begin
                if (x_hs_s && trk_dual_q[rptr_q]) begin
                    beat_d = BEAT1;
                end else begin
                    beat_d = BEAT0;
                end
            end
            BEAT1: begin
                if (x_hs_s) begin
                    beat_d = BEAT0;
                end else begin
                    beat_d = BEAT1;
                end
            end
            default: beat_d = BEAT0;
        endcase

        case ({issue_hs_s, pop_s})
            2'b10:   trk_cnt_d = trk_cnt_q + CntWidth'(1);
            2'b01:   trk_cnt_d = trk_cnt_q - CntWidth'(1);
            default: trk_cnt_d = trk_cnt_q;
        endcase

        case ({rsp_hs_s, pop_s})
            2'b10:   dat_cnt_d = dat_cnt_q + CntWidth'(1);
            2'b01:   dat_cnt_d = dat_cnt_q - CntWidth'(1);
            default: dat_cnt_d = dat_cnt_q;
        endcase

        issue_ready_d = (trk_cnt_d < DEPTH_C);
        c_ready_d     = (dat_cnt_d < trk_cnt_d);
        x_valid_d     = (dat_cnt_d != {CntWidth{1'b0}});

        if (x_valid_d) begin
            if (beat_d == BEAT1) begin
                x_rd_d   = trk_rd_d[rptr_d] + RegAddrWidth'(1);
                x_data_d = dat1_d[rptr_d];
            end else begin
                x_rd_d   = trk_rd_d[rptr_d];
                x_data_d = dat0_d[rptr_d];
            end
            x_err_d = dat_err_d[rptr_d];
        end else begin
            x_rd_d   = {RegAddrWidth{1'b0}};
            x_data_d = {DataWidth{1'b0}};
            x_err_d  = 1'b0;
        end
    end

    // State registers; reset drops every tracked and buffered entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            trk_rd_q      <= '{default: '0};
            trk_dual_q    <= '{default: '0};
            dat0_q        <= '{default: '0};
            dat1_q        <= '{default: '0};
            dat_err_q     <= '{default: '0};
            trk_wptr_q    <= {PtrWidth{1'b0}};
            dat_wptr_q    <= {PtrWidth{1'b0}};
            rptr_q        <= {PtrWidth{1'b0}};
            trk_cnt_q     <= {CntWidth{1'b0}};
            dat_cnt_q     <= {CntWidth{1'b0}};
            beat_q        <= BEAT0;
            issue_ready_q <= 1'b0;
            c_ready_q     <= 1'b0;
            x_valid_q     <= 1'b0;
            x_rd_q        <= {RegAddrWidth{1'b0}};
            x_data_q      <= {DataWidth{1'b0}};
            x_err_q       <= 1'b0;
        end else begin
            trk_rd_q      <= trk_rd_d;
            trk_dual_q    <= trk_dual_d;
            dat0_q        <= dat0_d;
            dat1_q        <= dat1_d;
            dat_err_q     <= dat_err_d;
            trk_wptr_q    <= trk_wptr_d;
            dat_wptr_q    <= dat_wptr_d;
            rptr_q        <= rptr_d;
            trk_cnt_q     <= trk_cnt_d;
            dat_cnt_q     <= dat_cnt_d;
            beat_q        <= beat_d;
            issue_ready_q <= issue_ready_d;
            c_ready_q     <= c_ready_d;
            x_valid_q     <= x_valid_d;
            x_rd_q        <= x_rd_d;
            x_data_q      <= x_data_d;
            x_err_q       <= x_err_d;
        end
    end

    assign bus.issue_ready_o = issue_ready_q;
    assign bus.c_rsp_ready_o = c_ready_q;
    assign bus.x_rsp_valid_o = x_valid_q;
    assign bus.x_rsp_rd_o    = x_rd_q;
    assign bus.x_rsp_data_o  = x_data_q;
    assign bus.x_rsp_error_o = x_err_q;
    assign bus.outstanding_o = trk_cnt_q;

    acc_wb_buffer_chk #(
        .Depth        (Depth),
        .DataWidth    (DataWidth),
        .RegAddrWidth (RegAddrWidth)
    ) u_chk (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .c_rsp_valid_i (bus.c_rsp_valid_i),
        .outstanding_i (trk_cnt_q),
        .x_valid_i     (x_valid_q),
        .x_ready_i     (bus.x_rsp_ready_i),
        .x_rd_i        (x_rd_q),
        .x_data_i      (x_data_q),
        .x_error_i     (x_err_q)
    );
endmodule

module acc_wb_buffer_chk #(
    parameter int Depth        = 4,
    parameter int DataWidth    = 32,
    parameter int RegAddrWidth = 5
) (
    input logic                         clk_i,
    input logic                         rst_i,
    input logic                         c_rsp_valid_i,
    input logic [$clog2(Depth+1)-1:0]   outstanding_i,
    input logic                         x_valid_i,
    input logic                         x_ready_i,
    input logic [RegAddrWidth-1:0]      x_rd_i,
    input logic [DataWidth-1:0]         x_data_i,
    input logic                         x_error_i
);
    logic [15:0] idle_cnt_q, idle_cnt_d;

    // Consecutive cycles a response is offered with nothing outstanding (saturating).
    always_comb begin
        if (c_rsp_valid_i && (outstanding_i == '0)) begin
            if (idle_cnt_q != 16'hFFFF) begin
                idle_cnt_d = idle_cnt_q + 16'd1;
            end else begin
                idle_cnt_d = idle_cnt_q;
            end
        end else begin
            idle_cnt_d = 16'd0;
        end
    end

    // Idle-response counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idle_cnt_q <= 16'd0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end

    unmatched_rsp_a: assert property (@(posedge clk_i) disable iff (rst_i)
        idle_cnt_q <= 16'(Depth))
        else $warning("c_rsp_valid held with no outstanding request");

    x_stable_a: assert property (@(posedge clk_i) disable iff (rst_i)
        (x_valid_i && !x_ready_i) |=>
        (x_valid_i && $stable(x_rd_i) && $stable(x_data_i) && $stable(x_error_i)))
        else $error("x_rsp outputs changed while stalled");
endmodule

// File: doc/acc_wb_buffer.md
Name: acc_wb_buffer

Overview:
- Response/writeback stage on the core side of the accelerator adapter.
- Tracks every adapter-issued request that expects a writeback.
- Buffers C-bus responses returning from the interconnect and presents them to the core X-response port, one register write per beat.
- Dual-writeback responses are serialized into two beats.
- Credit-based issue gating guarantees the buffer can never overflow.

Parameters:
DataWidth, 32, width of each response data word
Depth, 4, max outstanding writeback requests; tracking and data FIFO depth (>=1)
RegAddrWidth, 5, destination register address width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
issue_valid_i  in  1  adapter issues a request that expects writeback
issue_ready_o  out  1  credit available; issue accepted when valid&ready
issue_rd_i  in  RegAddrWidth  destination register of the issued request
issue_dualwb_i  in  1  request writes rd and rd+1
c_rsp_valid_i  in  1  C-bus response valid
c_rsp_ready_o  out  1  C-bus response accepted
c_rsp_data0_i  in  DataWidth  first result word
c_rsp_data1_i  in  DataWidth  second result word (dual writeback only)
c_rsp_error_i  in  1  accelerator error flag
x_rsp_valid_o  out  1  writeback beat valid
x_rsp_ready_i  in  1  core accepts writeback beat
x_rsp_rd_o  out  RegAddrWidth  register address of the beat
x_rsp_data_o  out  DataWidth  data of the beat
x_rsp_error_o  out  1  error flag of the beat
outstanding_o  out  $clog2(Depth+1)  issued requests not yet fully written back

Behaviour:
- Clock is clk_i. Reset rst_i is synchronous and active-high.
- C-bus responses return strictly in issue order; the block pairs the FIFO heads.
- Tracking FIFO:
  - Entries are {rd, dualwb}.
  - Pushed on an issue handshake.
  - Popped on the final writeback beat of its response.
- Data FIFO:
  - Entries are {data0, data1, error}.
  - Pushed on a c_rsp handshake.
  - Popped together with the tracking head.
- outstanding_o equals the tracking FIFO occupancy.
- issue_ready_o = (outstanding_o < Depth), taken from registered count only.
  - No same-cycle pass-through: when full, a simultaneous final-beat pop does not allow an issue in that cycle.
- c_rsp_ready_o = (data FIFO count < tracking FIFO count).
  - An unmatched response is back-pressured, never dropped.
  - No bypass: a response issued in the same cycle as its request is not accepted until the next cycle.
- x_rsp_valid_o = data FIFO non-empty.
  - Latency: c_rsp handshake in cycle t -> x_rsp_valid_o high in cycle t+1.
  - Once high, valid and all x_rsp_* outputs stay stable until x_rsp_ready_i is sampled high.
- Beat FSM has two states, BEAT0 and BEAT1.
  - BEAT0 drives rd = head.rd, data = head.data0, error = head.error.
    - On handshake with dualwb=0: pop both FIFOs, stay in BEAT0.
    - On handshake with dualwb=1: go to BEAT1, no pop.
  - BEAT1 drives rd = head.rd+1, truncated to RegAddrWidth (31 wraps to 0), data = head.data1, error = head.error.
    - On handshake: pop both FIFOs, go to BEAT0.
- outstanding_o decrements only on the final beat.
- Simultaneous issue and final pop in the same cycle: count unchanged, both FIFOs stay coherent.
- Simultaneous c_rsp push and x_rsp pop on a single-entry data FIFO: valid stays high, next entry presented the following cycle.
- FIFO pointers wrap modulo Depth; Depth need not be a power of two.
- Reset values (also while rst_i is high):
  - issue_ready_o=0, c_rsp_ready_o=0, x_rsp_valid_o=0.
  - x_rsp_rd_o=0, x_rsp_data_o=0, x_rsp_error_o=0.
  - outstanding_o=0, FSM=BEAT0.
- Reset mid-operation discards all tracked and buffered entries, including a half-completed dual writeback.
- issue_ready_o=1 in the first cycle after rst_i deasserts.
- Assertions:
  - No c_rsp_valid_i is held while outstanding_o==0 for more than Depth cycles (warning).
  - The x_rsp stability rule is checked.

Test Plan:
- Single issue rd=5, response data0=0xDEADBEEF -> one beat rd=5 data=0xDEADBEEF error=0, one cycle after the c_rsp handshake; outstanding 1->0.
- Dual issue rd=31, data0=0x1, data1=0x2 -> beats (rd=31, 0x1) then (rd=0, 0x2); outstanding decrements only after the second beat.
- Issue 4 requests with Depth=4 and no responses -> issue_ready_o=0, outstanding_o=4.
  - Drain one response -> issue_ready_o=1 the cycle after the final beat.
- c_rsp_valid_i asserted with no outstanding issue -> c_rsp_ready_o=0.
  - Issue rd=3 -> response accepted the next cycle.
- x_rsp_ready_i held low 10 cycles with 3 buffered responses (errors 0,1,0) -> outputs stable throughout; in-order delivery with matching rd and error values.
- Assert rst_i during BEAT1 of a dual writeback -> next cycle x_rsp_valid_o=0 and outstanding_o=0.
  - First cycle after release: issue_ready_o=1.
  - A new single issue completes normally.
